// File: rtl/mult_share_arbiter_if.sv
// Requester/consumer bundle for the shared multiplier: operand handshake in,
// tagged product out, plus a busy status.
interface mult_share_arbiter_if #(
  parameter int op_width = 4,
  parameter int num_req  = 2
);
  logic [num_req-1:0]          req_valid;
  logic [num_req-1:0]          req_ready;
  logic [num_req*op_width-1:0] req_a;
  logic [num_req*op_width-1:0] req_b;
  logic                        resp_valid;
  logic                        resp_ready;
  logic [2*op_width-1:0]       resp_product;
  logic [1:0]                  resp_id;
  logic                        busy;

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_product, resp_id, busy
  );
  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_product, resp_id, busy
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one iterative shift-add multiplier between
// num_req requesters; the product is held, tagged by requester, until accepted.
module mult_share_arbiter #(
  parameter int op_width = 4,
  parameter int num_req  = 2
) (
  input  logic               clk,
  input  logic               reset,
  mult_share_arbiter_if.slave bus
);
  localparam int pw = 2 * op_width;
  localparam int cw = (op_width > 1) ? $clog2(op_width) : 1;
  localparam logic [cw-1:0] cnt_last   = cw'(op_width - 1);
  localparam logic [1:0]    grant_init = 2'(num_req - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state, state_nxt;
  logic [1:0]            last_grant, grant_id, id_reg;
  logic                  grant_any, take;
  logic [op_width-1:0]   a_sel, b_sel, b_reg;
  logic [pw-1:0]         a_shift, acc, acc_sum;
  logic [cw-1:0]         cnt;

  // Scan last_grant+1, last_grant+2, ... modulo num_req; first valid wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = 1; k <= num_req; k++) begin
      for (int i = 0; i < num_req; i++) begin
        if (!grant_any && bus.req_valid[i] &&
            ((int'(last_grant) + k) % num_req) == i) begin
          grant_any = 1'b1;
          grant_id  = 2'(i);
        end
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    a_sel         = '0;
    b_sel         = '0;
    for (int i = 0; i < num_req; i++) begin
      bus.req_ready[i] = reset && (state == IDLE) && grant_any && (grant_id == 2'(i));
      if (grant_id == 2'(i)) begin
        a_sel = bus.req_a[i*op_width +: op_width];
        b_sel = bus.req_b[i*op_width +: op_width];
      end
    end
  end

  assign take    = |(bus.req_valid & bus.req_ready);
  assign acc_sum = acc + (b_reg[0] ? a_shift : '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = BUSY;
      BUSY:    if (cnt == cnt_last) state_nxt = DONE;
      DONE:    if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant       <= grant_init;
      id_reg           <= '0;
      a_shift          <= '0;
      b_reg            <= '0;
      acc              <= '0;
      cnt              <= '0;
      bus.resp_product <= '0;
      bus.resp_id      <= '0;
      bus.resp_valid   <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      bus.busy       <= (state_nxt != IDLE);
      bus.resp_valid <= (state_nxt == DONE);
      case (state)
        IDLE: if (take) begin
          a_shift    <= {{op_width{1'b0}}, a_sel};
          b_reg      <= b_sel;
          id_reg     <= grant_id;
          last_grant <= grant_id;
          acc        <= '0;
          cnt        <= '0;
        end
        BUSY: begin
          acc     <= acc_sum;
          a_shift <= a_shift << 1;
          b_reg   <= b_reg >> 1;
          cnt     <= cnt + 1'b1;
          // Final partial product lands in the same cycle as the DONE transition.
          if (cnt == cnt_last) begin
            bus.resp_product <= acc_sum;
            bus.resp_id      <= id_reg;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: reset, single op, round-robin,
// backpressure, boundary operands, mid-op reset and withdrawn requests.
module tb_mult_share_arbiter;
  localparam int W = 4;
  localparam int N = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  mult_share_arbiter_if #(.op_width(W), .num_req(N)) bus();
  mult_share_arbiter #(.op_width(W), .num_req(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
  endtask

  task automatic test_reset;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.resp_ready = 1'b0;
    reset = 1'b0;
    step; step;
    checks++; if (bus.req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b exp=00", bus.req_ready); end
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.resp_product !== 8'd0) begin failures++; $display("FAIL reset_product got=%0d exp=0", bus.resp_product); end
    checks++; if (bus.resp_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", bus.resp_id); end
    reset = 1'b1;
    step;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_single;
    int lat;
    set_ops(0, 4'd13, 4'd11); bus.req_valid = 2'b01; bus.resp_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL single_grant got=%b exp=01", bus.req_ready); end
    step;
    bus.req_valid = '0;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
    lat = 0;
    while (bus.resp_valid !== 1'b1 && lat < 10) begin step; lat++; end
    checks++; if (lat != 4) begin failures++; $display("FAIL single_latency got=%0d exp=4", lat); end
    checks++; if (bus.resp_product !== 8'd143) begin failures++; $display("FAIL single_product got=%0d exp=143", bus.resp_product); end
    checks++; if (bus.resp_id !== 2'd0) begin failures++; $display("FAIL single_id got=%0d exp=0", bus.resp_id); end
    step;
    checks++; if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL single_release got=%b%b exp=00", bus.resp_valid, bus.busy); end
  endtask

  task automatic test_round_robin;
    int ng, nr, cyc;
    int gid[4];
    int gcyc[4];
    reset = 1'b0; step; reset = 1'b1;
    set_ops(0, 4'd3, 4'd5); set_ops(1, 4'd7, 4'd9);
    bus.req_valid = 2'b11; bus.resp_ready = 1'b1;
    ng = 0; nr = 0; cyc = 0;
    while (nr < 4 && cyc < 60) begin
      #1;
      if (bus.req_ready != 2'b00 && ng < 4) begin
        gid[ng] = (bus.req_ready == 2'b10) ? 1 : (bus.req_ready == 2'b01) ? 0 : 9;
        gcyc[ng] = cyc; ng++;
      end
      if (bus.resp_valid === 1'b1) begin
        checks++; if (bus.resp_id !== 2'(nr % 2)) begin failures++; $display("FAIL rr_resp_id[%0d] got=%0d exp=%0d", nr, bus.resp_id, nr % 2); end
        checks++; if (bus.resp_product !== ((nr % 2) ? 8'd63 : 8'd15)) begin failures++; $display("FAIL rr_product[%0d] got=%0d exp=%0d", nr, bus.resp_product, (nr % 2) ? 63 : 15); end
        nr++;
      end
      step; cyc++;
    end
    bus.req_valid = '0;
    checks++; if (nr != 4 || ng != 4) begin failures++; $display("FAIL rr_counts got=%0d/%0d exp=4/4", ng, nr); end
    for (int k = 0; k < ng; k++) begin
      checks++; if (gid[k] != k % 2) begin failures++; $display("FAIL rr_grant[%0d] got=%0d exp=%0d", k, gid[k], k % 2); end
      if (k > 0) begin
        checks++; if (gcyc[k] - gcyc[k-1] != 6) begin failures++; $display("FAIL rr_spacing[%0d] got=%0d exp=6", k, gcyc[k] - gcyc[k-1]); end
      end
    end
    step;
  endtask

  task automatic test_backpressure;
    bit bad;
    bus.resp_ready = 1'b0;
    set_ops(0, 4'd6, 4'd7); bus.req_valid = 2'b01;
    step;
    bus.req_valid = 2'b11;
    repeat (4) step;
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (bus.resp_valid !== 1'b1 || bus.resp_product !== 8'd42 || bus.resp_id !== 2'd0 || bus.req_ready !== 2'b00) begin
        bad = 1'b1;
        $display("FAIL bp_hold cyc=%0d got=v%b p%0d id%0d rdy%b exp=v1 p42 id0 rdy00", k, bus.resp_valid, bus.resp_product, bus.resp_id, bus.req_ready);
      end
      checks++; if (bad) failures++;
      bad = 1'b0;
      step;
    end
    bus.resp_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 2'b00) begin failures++; $display("FAIL bp_same_edge_grant got=%b exp=00", bus.req_ready); end
    step;
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b exp=0", bus.resp_valid); end
    checks++; if (bus.req_ready !== 2'b10) begin failures++; $display("FAIL bp_next_grant got=%b exp=10", bus.req_ready); end
    bus.req_valid = '0;
    step;
  endtask

  task automatic run_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] exp);
    int lat;
    logic [N-1:0] oh;
    oh = '0; oh[i] = 1'b1;
    set_ops(i, a, b); bus.req_valid = oh; bus.resp_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== oh) begin failures++; $display("FAIL op_%0dx%0d_grant got=%b exp=%b", a, b, bus.req_ready, oh); end
    step;
    bus.req_valid = '0;
    lat = 0;
    while (bus.resp_valid !== 1'b1 && lat < 10) begin step; lat++; end
    checks++; if (lat != 4) begin failures++; $display("FAIL op_%0dx%0d_latency got=%0d exp=4", a, b, lat); end
    checks++; if (bus.resp_product !== exp) begin failures++; $display("FAIL op_%0dx%0d_product got=%0d exp=%0d", a, b, bus.resp_product, exp); end
    checks++; if (bus.resp_id !== 2'(i)) begin failures++; $display("FAIL op_%0dx%0d_id got=%0d exp=%0d", a, b, bus.resp_id, i); end
    step;
  endtask

  task automatic test_boundary;
    run_op(0, 4'd15, 4'd15, 8'd225);
    run_op(1, 4'd0,  4'd9,  8'd0);
    run_op(0, 4'd1,  4'd15, 8'd15);
    run_op(1, 4'd12, 4'd10, 8'd120);
  endtask

  task automatic test_reset_mid_busy;
    bit seen;
    set_ops(1, 4'd5, 4'd5); bus.req_valid = 2'b10; bus.resp_ready = 1'b1;
    step;
    bus.req_valid = '0;
    step; step;
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", bus.resp_valid); end
    checks++; if (bus.resp_product !== 8'd0) begin failures++; $display("FAIL rst_mid_product got=%0d exp=0", bus.resp_product); end
    checks++; if (bus.resp_id !== 2'd0) begin failures++; $display("FAIL rst_mid_id got=%0d exp=0", bus.resp_id); end
    bus.req_valid = 2'b11;
    #1;
    checks++; if (bus.req_ready !== 2'b00) begin failures++; $display("FAIL rst_mid_ready got=%b exp=00", bus.req_ready); end
    step; step;
    reset = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL rst_restart_grant got=%b exp=01", bus.req_ready); end
    bus.req_valid = '0;
    seen = 1'b0;
    repeat (6) begin step; if (bus.resp_valid !== 1'b0) seen = 1'b1; end
    checks++; if (seen) begin failures++; $display("FAIL rst_no_resp got=1 exp=0"); end
  endtask

  task automatic test_withdrawn;
    int lat;
    bus.resp_ready = 1'b1;
    set_ops(0, 4'd2, 4'd3); bus.req_valid = 2'b01;
    step;
    bus.req_valid = '0;
    step;
    set_ops(1, 4'd9, 4'd9); bus.req_valid = 2'b10;
    #1;
    checks++; if (bus.req_ready !== 2'b00) begin failures++; $display("FAIL wd_busy_ready got=%b exp=00", bus.req_ready); end
    step;
    bus.req_valid = '0;
    set_ops(0, 4'd4, 4'd4); bus.req_valid = 2'b01;
    lat = 0;
    while (bus.resp_valid !== 1'b1 && lat < 10) begin step; lat++; end
    checks++; if (bus.resp_product !== 8'd6 || bus.resp_id !== 2'd0) begin failures++; $display("FAIL wd_first got=%0d/%0d exp=6/0", bus.resp_product, bus.resp_id); end
    step;
    checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL wd_next_grant got=%b exp=01", bus.req_ready); end
    step;
    bus.req_valid = '0;
    lat = 0;
    while (bus.resp_valid !== 1'b1 && lat < 10) begin step; lat++; end
    checks++; if (bus.resp_product !== 8'd16 || bus.resp_id !== 2'd0) begin failures++; $display("FAIL wd_second got=%0d/%0d exp=16/0", bus.resp_product, bus.resp_id); end
    step;
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_backpressure;
    test_boundary;
    test_reset_mid_busy;
    test_withdrawn;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin arbiter and sequencer that shares one iterative shift-add multiplier between `num_req` requesters. Each requester hands over an operand pair with a valid/ready handshake. The block grants one requester at a time and runs the multiply over `op_width` cycles. It then holds the product, tagged with the requester index, until the consumer accepts it. It sits between the counter/squaring datapaths of the multiplier group and a single shared multiply resource.

## Interface
Parameters:
- `op_width`, 4, width of each operand; the product is `2*op_width` bits.
- `num_req`, 2, number of requesters, legal range 2..4.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset (0 = in reset).
- `req_valid`  in  `num_req`  bit i high means requester i presents an operand pair.
- `req_a`  in  `num_req*op_width`  packed multiplicands; requester i uses bits `[i*op_width +: op_width]`.
- `req_b`  in  `num_req*op_width`  packed multipliers, same packing as `req_a`.
- `req_ready`  out  `num_req`  one-hot or zero; bit i high means requester i is granted this cycle.
- `resp_valid`  out  1  product available.
- `resp_product`  out  `2*op_width`  unsigned product `a*b`.
- `resp_id`  out  2  index of the requester that owns the product.
- `resp_ready`  in  1  consumer accepts the product.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - BUSY: running the multiply.
  - DONE: holding the product for the consumer.
- Reset (`reset`=0, asynchronous):
  - state forced to IDLE; `last_grant` set to `num_req-1`, so requester 0 has first priority.
  - accumulator, operand registers, counter, `resp_product` and `resp_id` cleared to 0.
  - `resp_valid`=0, `busy`=0, `req_ready`=0.
- Arbitration (IDLE only, combinational):
  - Scan order is `last_grant+1, last_grant+2, …`, wrapping modulo `num_req`.
  - The first requester with `req_valid` high gets `req_ready`; all other `req_ready` bits stay 0.
  - `req_ready` is all-zero in BUSY and DONE.
- Handshake: a transfer occurs on a rising edge where `req_valid[i] && req_ready[i]`. On that edge:
  - capture `a`, `b` and `id=i`;
  - set `last_grant=i`;
  - clear accumulator and counter to 0;
  - move to BUSY.
- Requests are not sticky. A requester may drop `req_valid` before it is granted, and the grant is recomputed every cycle. Operand changes after the transfer are ignored.
- BUSY: each cycle
  - if `b_reg[0]`, add `a_shift` (`2*op_width` bits) to the accumulator;
  - shift `a_shift` left by 1 and `b_reg` right by 1;
  - increment the counter.
  - When the counter reaches `op_width-1`, the final add is done in that same cycle and the FSM moves to DONE.
  - BUSY lasts exactly `op_width` cycles regardless of operand values; there is no early exit for zero operands.
- Arithmetic: unsigned. The accumulator is `2*op_width` bits and cannot overflow; maximum result is `(2^op_width-1)^2` (225 for `op_width`=4).
- DONE:
  - `resp_valid`=1; `resp_product` and `resp_id` held stable.
  - On an edge with `resp_ready`=1, move to IDLE and deassert `resp_valid`.
  - If `resp_ready` stays low, the FSM waits indefinitely and no new grant is issued.
- `resp_id` is zero-extended to 2 bits for `num_req`=2 or 3.

## Timing
- Transfer on edge T0. BUSY occupies cycles T0..T0+`op_width`-1. `resp_valid` rises after edge T0+`op_width`.
- With `resp_ready` tied high:
  - DONE lasts 1 cycle and IDLE lasts at least 1 cycle;
  - minimum transfer-to-transfer spacing is `op_width+2` cycles (6 for the defaults).
- `req_ready` is combinational from state, `req_valid` and `last_grant`. All other outputs are registered.
- Reset asserted in BUSY or DONE aborts the operation immediately. No `resp_valid` is produced for the aborted request. After release, arbitration restarts with requester 0 first.
- `resp_ready` is ignored outside DONE.
- Same-edge events: when `resp_ready` is accepted in DONE, the state is DONE for that cycle, so `req_ready` stays 0. A pending request is granted in the following IDLE cycle, never in the same cycle.

## Test plan
- Single request: reset, then requester 0 presents a=13, b=11 with `resp_ready`=1.
  - Expect `req_ready[0]` the same cycle.
  - Expect `resp_valid` 4 cycles after the transfer, with `resp_product`=143 and `resp_id`=0.
- Round-robin under contention: both requesters hold `req_valid` continuously with `resp_ready`=1.
  - Grants alternate 0,1,0,1.
  - Transfers are spaced 6 cycles apart.
  - `resp_id` alternates to match.
- Backpressure: hold `resp_ready`=0 for 10 cycles in DONE.
  - `resp_valid`, `resp_product` and `resp_id` stay stable.
  - `req_ready` stays all-zero.
  - Product is released on the first cycle with `resp_ready`=1.
- Boundary operands:
  - 15×15 gives 225.
  - 0×9 gives 0 with unchanged latency of 4 cycles.
  - 1×15 gives 15.
- Reset mid-BUSY: drop `reset` 2 cycles after a transfer from requester 1.
  - All outputs return to 0 asynchronously.
  - No response is produced.
  - After release with both requesters valid, requester 0 is granted first.
- Withdrawn request: requester 1 raises `req_valid` for 1 cycle while the arbiter is BUSY, then drops it.
  - No transfer occurs for requester 1.
  - The next grant goes to whichever requester is valid when the FSM is next in IDLE.
